// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and ALU-control definitions for the ALU sequencer.
package alu_seq_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_NEG = 4'd3;
  localparam logic [OP_W-1:0] OP_BRZ = 4'd4;
  localparam logic [OP_W-1:0] OP_BRN = 4'd5;
  localparam logic [OP_W-1:0] OP_JMP = 4'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic add;
    logic neg;
    logic sub;
  } alu_ctrl_t;

  localparam alu_ctrl_t CTRL_NONE = '{add: 1'b0, neg: 1'b0, sub: 1'b0};
  localparam alu_ctrl_t CTRL_ADD  = '{add: 1'b1, neg: 1'b0, sub: 1'b0};
  localparam alu_ctrl_t CTRL_SUB  = '{add: 1'b1, neg: 1'b0, sub: 1'b1};
  localparam alu_ctrl_t CTRL_NEG  = '{add: 1'b1, neg: 1'b1, sub: 1'b0};

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NEG);
  endfunction

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return op > OP_JMP;
  endfunction

  // Never yields sub and neg together; that pairing is undefined at the ALU.
  function automatic alu_ctrl_t ctrl_for(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD:  return CTRL_ADD;
      OP_SUB:  return CTRL_SUB;
      OP_NEG:  return CTRL_NEG;
      default: return CTRL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch resolution against the stored ALU flags.
module branch_cond
  import alu_seq_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic            i_flag_z,
  input  logic            i_flag_n,
  output logic            o_taken
);

  always_comb begin
    // NOTE: default first so every path assigns o_taken and no latch is inferred.
    o_taken = 1'b0;
    case (i_op)
      OP_BRZ:  o_taken = i_flag_z;
      OP_BRN:  o_taken = i_flag_n;
      OP_JMP:  o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issues ALU ops over a valid/ready handshake, captures results/flags,
// resolves branches and owns the program counter.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [PC_W-1:0]   instr_tgt,
  output logic              alu_add,
  output logic              alu_neg,
  output logic              alu_sub,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              flag_z,
  output logic              flag_n,
  output logic [PC_W-1:0]   pc,
  output logic              branch_taken,
  output logic              illegal_op
);

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_INC = PC_W'(1);

  state_t            r_state;
  alu_ctrl_t         r_ctrl;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_res_data;
  logic              r_flag_z;
  logic              r_flag_n;
  logic              r_res_valid;
  logic              r_branch_taken;
  logic              r_illegal;
  logic              w_taken;

  branch_cond u_branch_cond (
    .i_op     (instr_op),
    .i_flag_z (r_flag_z),
    .i_flag_n (r_flag_n),
    .o_taken  (w_taken)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_ctrl         <= CTRL_NONE;
      r_pc           <= PC_RST;
      r_res_data     <= '0;
      r_flag_z       <= 1'b0;
      r_flag_n       <= 1'b0;
      r_res_valid    <= 1'b0;
      r_branch_taken <= 1'b0;
      r_illegal      <= 1'b0;
    end else begin
      r_branch_taken <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            if (is_alu_op(instr_op)) begin
              r_state <= S_EXEC;
              r_ctrl  <= ctrl_for(instr_op);
            end else begin
              if (w_taken) begin
                r_pc           <= instr_tgt;
                r_branch_taken <= 1'b1;
              end else begin
                r_pc <= r_pc + PC_INC;
              end
              if (is_illegal(instr_op)) r_illegal <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          r_res_data  <= alu_out;
          r_flag_z    <= alu_z;
          r_flag_n    <= alu_n;
          r_ctrl      <= CTRL_NONE;
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            r_pc        <= r_pc + PC_INC;
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ctrl  <= CTRL_NONE;
        end
      endcase
    end
  end

  assign instr_ready  = (r_state == S_IDLE);
  assign alu_add      = r_ctrl.add;
  assign alu_neg      = r_ctrl.neg;
  assign alu_sub      = r_ctrl.sub;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign flag_z       = r_flag_z;
  assign flag_n       = r_flag_n;
  assign pc           = r_pc;
  assign branch_taken = r_branch_taken;
  assign illegal_op   = r_illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU and sequencer model.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int DATA_W = 32;
  localparam int PC_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [3:0]        instr_op = '0;
  logic [PC_W-1:0]   instr_tgt = '0;
  logic              alu_add, alu_neg, alu_sub;
  logic [DATA_W-1:0] alu_out;
  logic              alu_z, alu_n;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [DATA_W-1:0] res_data;
  logic              flag_z, flag_n;
  logic [PC_W-1:0]   pc;
  logic              branch_taken;
  logic              illegal_op;

  alu_sequencer #(.DATA_W(DATA_W), .PC_W(PC_W), .RESET_PC(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_tgt    (instr_tgt),
    .alu_add      (alu_add),
    .alu_neg      (alu_neg),
    .alu_sub      (alu_sub),
    .alu_out      (alu_out),
    .alu_z        (alu_z),
    .alu_n        (alu_n),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .pc           (pc),
    .branch_taken (branch_taken),
    .illegal_op   (illegal_op)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External ALU model: responds to the control lines; junk when idle so a
  // mistimed capture shows up.
  logic [DATA_W-1:0] op_a = '0, op_b = '0;
  always_comb begin
    alu_out = 32'hA5A5_0F0F ^ op_a;
    case ({alu_add, alu_sub, alu_neg})
      3'b100:  alu_out = op_a + op_b;
      3'b110:  alu_out = op_a - op_b;
      3'b101:  alu_out = 32'd0 - op_a;
      default: ;
    endcase
  end
  assign alu_z = (alu_out == '0);
  assign alu_n = alu_out[DATA_W-1];

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              z;
    logic              n;
  } res_t;
  res_t sb_q[$];

  logic [PC_W-1:0] m_pc  = '0;
  logic            m_z   = 1'b0;
  logic            m_n   = 1'b0;
  logic            m_ill = 1'b0;

  // res_ready policy: 0 random, 1 held low, 2 held high.
  int rr_mode = 2;
  initial forever begin
    @(posedge clk); #1;
    case (rr_mode)
      0:       res_ready = 1'($urandom_range(0, 1));
      1:       res_ready = 1'b0;
      default: res_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on each result handshake and checks holding.
  logic              prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (res_valid && prev_hold) check("res_data_stable", res_data, prev_data);
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          res_t e;
          e = sb_q.pop_front();
          check("res_data", res_data, e.d);
          check("flag_z", flag_z, e.z);
          check("flag_n", flag_n, e.n);
        end
      end
      prev_hold = res_valid && !res_ready;
      prev_data = res_data;
    end
  end

  task automatic wait_ready(input string name);
    int waited = 0;
    while (instr_ready !== 1'b1 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 200) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [PC_W-1:0] tgt,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input int hold);
    logic [DATA_W-1:0] r;
    logic [2:0]        exp_ctrl;
    logic              taken;
    wait_ready("issue_wait");
    op_a = a; op_b = b;
    instr_valid = 1'b1; instr_op = op; instr_tgt = tgt;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (op == OP_ADD || op == OP_SUB || op == OP_NEG) begin
      case (op)
        OP_ADD:  begin r = a + b; exp_ctrl = 3'b100; end
        OP_SUB:  begin r = a - b; exp_ctrl = 3'b110; end
        default: begin r = -a;    exp_ctrl = 3'b101; end
      endcase
      sb_q.push_back('{d: r, z: (r == '0), n: r[DATA_W-1]});
      m_z = (r == '0); m_n = r[DATA_W-1]; m_pc = m_pc + 1'b1;
      check("exec_ctrl", {alu_add, alu_sub, alu_neg}, exp_ctrl);
      check("exec_not_ready", instr_ready, 0);
      check("exec_no_valid", res_valid, 0);
      @(posedge clk); #1;
      check("done_ctrl", {alu_add, alu_sub, alu_neg}, 0);
      check("done_valid", res_valid, 1);
      for (int i = 0; i < hold; i++) begin
        check("hold_valid", res_valid, 1);
        check("hold_not_ready", instr_ready, 0);
        check("hold_data", res_data, r);
        @(posedge clk); #1;
      end
      if (hold > 0) rr_mode = 2;
      wait_ready("done_wait");
      check("alu_pc", pc, m_pc);
    end else begin
      taken = (op == OP_JMP) || (op == OP_BRZ && m_z) || (op == OP_BRN && m_n);
      m_pc = taken ? tgt : m_pc + 1'b1;
      if (op > OP_JMP) m_ill = 1'b1;
      check("branch_taken", branch_taken, taken);
      check("pc", pc, m_pc);
      check("single_ready", instr_ready, 1);
      check("single_ctrl", {alu_add, alu_sub, alu_neg}, 0);
    end
    check("illegal_op", illegal_op, m_ill);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_pc"}, pc, 0);
    check({name, "_res_valid"}, res_valid, 0);
    check({name, "_res_data"}, res_data, 0);
    check({name, "_flags"}, {flag_z, flag_n}, 0);
    check({name, "_ctrl"}, {alu_add, alu_sub, alu_neg}, 0);
    check({name, "_branch"}, branch_taken, 0);
    check({name, "_illegal"}, illegal_op, 0);
    check({name, "_ready"}, instr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] a, b;
    logic [3:0]        op;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(OP_ADD, 8'h00, 32'd5, 32'd7, 0);
    issue(OP_SUB, 8'h00, 32'd3, 32'd3, 0);
    issue(OP_BRZ, 8'h40, '0, '0, 0);
    @(posedge clk); #1;
    check("branch_pulse_end", branch_taken, 0);

    rr_mode = 1;
    issue(OP_NEG, 8'h00, 32'd9, 32'd0, 5);
    issue(OP_BRN, 8'h10, '0, '0, 0);

    issue(OP_JMP, 8'hFF, '0, '0, 0);
    issue(OP_NOP, 8'h00, '0, '0, 0);
    issue(OP_NOP, 8'h00, '0, '0, 0);
    issue(OP_NOP, 8'h00, '0, '0, 0);
    issue(OP_JMP, 8'h22, '0, '0, 0);
    issue(OP_BRZ, 8'h77, '0, '0, 0);

    issue(4'hB, 8'h00, '0, '0, 0);
    issue(OP_NOP, 8'h00, '0, '0, 0);

    // Reset in the middle of EXEC: the aborted ADD must never produce a result.
    op_a = 32'd1; op_b = 32'd2;
    instr_valid = 1'b1; instr_op = OP_ADD;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("abort_exec_ctrl", {alu_add, alu_sub, alu_neg}, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    m_pc = '0; m_z = 1'b0; m_n = 1'b0; m_ill = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_valid", res_valid, 0);
    end
    issue(OP_ADD, 8'h00, 32'hFFFF_FFFF, 32'd1, 0);

    rr_mode = 0;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue(op, 8'($urandom), a, b, 0);
    end

    rr_mode = 2;
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control-side counterpart of the 32-bit ALU. Accepts opcodes over a valid/ready handshake and drives the ALU control lines add/neg/sub.
- Captures the ALU result and its Z/N flags into registers, evaluates conditional branches against the stored flags, and maintains the program counter.
- Sits between instruction fetch and the ALU datapath. Operand muxing stays in the datapath.

Parameters:
- DATA_W, 32, width of the ALU result and of res_data.
- PC_W, 8, program counter width.
- RESET_PC, 0, pc value after reset.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  4  opcode.
- instr_tgt  in  PC_W  branch/jump target.
- alu_add  out  1  ALU add control.
- alu_neg  out  1  ALU negate control.
- alu_sub  out  1  ALU subtract control.
- alu_out  in  DATA_W  ALU combinational result.
- alu_z  in  1  ALU zero flag.
- alu_n  in  1  ALU negative flag.
- res_valid  out  1  captured result available.
- res_ready  in  1  result consumer ready.
- res_data  out  DATA_W  captured ALU result.
- flag_z  out  1  stored zero flag.
- flag_n  out  1  stored negative flag.
- pc  out  PC_W  program counter.
- branch_taken  out  1  one-cycle pulse, pc was loaded from a target.
- illegal_op  out  1  sticky, set on an undefined opcode.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC.
  - res_data=0, flag_z=0, flag_n=0, res_valid=0.
  - branch_taken=0, illegal_op=0, all alu_* controls=0.
  - Reset asserted mid-operation aborts the operation; no partial result is kept.
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 NEG, 4 BRZ, 5 BRN, 6 JMP.
  - 7-15 are illegal: handled as NOP and set illegal_op.
- States are IDLE, EXEC, DONE. instr_ready=1 only in IDLE.
- Acceptance occurs when instr_valid & instr_ready at an edge (cycle T).
- ALU ops (ADD/SUB/NEG):
  - Go IDLE->EXEC. EXEC lasts exactly one cycle (T+1).
  - Controls in EXEC:
    - ADD: add=1, neg=0, sub=0.
    - SUB: add=1, sub=1, neg=0.
    - NEG: add=1, neg=1, sub=0.
  - Controls are all 0 in every other state.
  - sub and neg are never both 1; {sub,neg}=11 is illegal at the ALU.
  - At the end of EXEC, alu_out, alu_z and alu_n are registered into res_data, flag_z and flag_n. State goes to DONE.
  - DONE: res_valid=1 from T+2. It is held, with res_data stable, until res_valid & res_ready.
  - On the DONE handshake: pc<=pc+1, state<=IDLE, res_valid drops the next cycle.
  - Minimum ALU-op throughput is one per 3 cycles.
- Single-cycle ops: NOP, BRZ, BRN, JMP and illegal opcodes stay in IDLE. instr_ready stays 1, so back-to-back issue is allowed.
  - NOP and illegal opcodes: pc<=pc+1.
  - BRZ: taken iff flag_z=1. BRN: taken iff flag_n=1. JMP: always taken.
  - Taken: pc<=instr_tgt and branch_taken=1 for exactly the cycle after acceptance. Not taken: pc<=pc+1.
  - Branch conditions use the stored flags from the last completed ALU op, not the live alu_z/alu_n.
  - Flags are unchanged by non-ALU ops.
- PC arithmetic is modulo 2^PC_W: all-ones+1 wraps to 0. A taken branch to its own address is legal.
- illegal_op is cleared only by reset.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_NOP..OP_JMP;
  - state encoding S_IDLE/S_EXEC/S_DONE;
  - ALU control triple constants CTRL_ADD/CTRL_SUB/CTRL_NEG.
- One natural sub-module, branch_cond: a combinational taken-evaluation from opcode and stored flags.
- Everything else lives in one FSM module.

Test Plan:
- Reset, then issue ADD. The ALU model returns 5+7 → controls 100 only at T+1; res_data=12, flag_z=0, flag_n=0, res_valid at T+2; pc 0→1 after res handshake.
- SUB with model result 3-3=0, then BRZ tgt=0x40 → flag_z=1, branch_taken pulse one cycle, pc=0x40.
- NEG of 9 (result 0xFFFFFFF7) with res_ready held low 5 cycles → res_valid and res_data stable, instr_ready=0 throughout. Then BRN tgt=0x10 is taken.
- pc=0xFF, then NOP → pc=0x00. Then back-to-back NOP, NOP, JMP 0x22 on consecutive cycles → pc 1, 2, 0x22, instr_ready stays 1.
- Opcode 0xB → illegal_op=1 and stays 1; pc increments; no alu_* activity.
- rst_n pulsed low during EXEC → all outputs return to reset values immediately, res_valid never asserts, and the next ADD behaves normally.
